svc_rv_div_sched: RTL and testbench

SVC_RV_DIV_SCHED -- requirements
Module: svc_rv_div_sched

---
 rtl/svc_rv_div_sched.sv | 146 ++++++++++++++
 tb/tb_svc_rv_div_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_div_sched.sv
// Arbitrates NREQ requesters onto one shared multi-cycle divider.
// Grants are round-robin, and each requester can cancel its own operation.
module svc_rv_div_sched #(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_rs1,
  input  logic [NREQ*XLEN-1:0] req_rs2,
  input  logic [NREQ*3-1:0]    req_op,
  input  logic [NREQ-1:0]      flush,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [XLEN-1:0]      resp_result,
  output logic                 div_en,
  output logic [XLEN-1:0]      div_rs1,
  output logic [XLEN-1:0]      div_rs2,
  output logic [2:0]           div_op,
  input  logic                 div_busy,
  input  logic [XLEN-1:0]      div_result,
  output logic                 sched_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_last_grant;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   w_win;
  logic            w_found;
  logic            w_grant;
  logic            w_owner_flush;
  logic            r_rst_dly;
  logic [NREQ-1:0] w_elig;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_result;
  logic [2:0]      r_op;

  // A requester cancelling in the same cycle it asks is not eligible.
  assign w_elig        = req_valid & ~flush;
  assign w_owner_flush = flush[r_owner];
  // No grant while reset is applied or on the first cycle after it.
  assign w_grant       = (r_state == S_IDLE) && w_found && rst_n && !r_rst_dly;

  // Round-robin search starting one past the last completed owner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && w_elig[(int'(r_last_grant) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(r_last_grant) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_next = S_ISSUE;
      S_ISSUE: w_next = w_owner_flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (w_owner_flush)  w_next = S_DRAIN;
        else if (!div_busy) w_next = S_RESP;
      end
      S_RESP:  if (w_owner_flush || resp_ready[r_owner]) w_next = S_IDLE;
      S_DRAIN: if (!div_busy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: holding and result registers are ordinary flops, so they are cleared on reset like the FSM.
    if (!rst_n) begin
      r_last_grant <= IW'(NREQ - 1);
      r_owner      <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_op         <= '0;
      r_result     <= '0;
      r_rst_dly    <= 1'b1;
    end else begin
      r_rst_dly <= 1'b0;
      if (w_grant) begin
        r_owner <= w_win;
        r_rs1   <= req_rs1[w_win*XLEN +: XLEN];
        r_rs2   <= req_rs2[w_win*XLEN +: XLEN];
        r_op    <= req_op[w_win*3 +: 3];
      end
      if (r_state == S_WAIT && !w_owner_flush && !div_busy) r_result <= div_result;
      // Only a delivered response moves the round-robin pointer.
      if (r_state == S_RESP && !w_owner_flush && resp_ready[r_owner]) r_last_grant <= r_owner;
    end
  end

  always_comb begin
    req_ready   = '0;
    resp_valid  = '0;
    resp_result = '0;
    div_en      = 1'b0;
    div_rs1     = '0;
    div_rs2     = '0;
    div_op      = '0;
    sched_busy  = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_grant) req_ready[w_win] = 1'b1;
      S_ISSUE: begin
        div_en  = 1'b1;
        div_rs1 = r_rs1;
        div_rs2 = r_rs2;
        div_op  = r_op;
      end
      S_WAIT, S_DRAIN: begin
        div_rs1 = r_rs1;
        div_rs2 = r_rs2;
        div_op  = r_op;
      end
      S_RESP: begin
        resp_valid[r_owner] = 1'b1;
        resp_result         = r_result;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_svc_rv_div_sched.sv
// Self-checking bench for svc_rv_div_sched with a behavioural divider and RISC-V reference.
// Covers directed scenarios plus randomized single-requester ops.
module tb_svc_rv_div_sched;

  localparam int XLEN = 32;
  localparam int NREQ = 2;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready, flush, resp_valid, resp_ready;
  logic [NREQ*XLEN-1:0] req_rs1, req_rs2;
  logic [NREQ*3-1:0]    req_op;
  logic [XLEN-1:0]      resp_result, div_rs1, div_rs2, div_result, dres;
  logic [2:0]           div_op;
  logic                 div_en, div_busy, sched_busy;

  int checks   = 0;
  int failures = 0;
  int lat      = 4;
  int dcnt;
  int exp_last = NREQ - 1;

  svc_rv_div_sched #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_op(req_op),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .div_en(div_en), .div_rs1(div_rs1), .div_rs2(div_rs2), .div_op(div_op),
    .div_busy(div_busy), .div_result(div_result),
    .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  // RISC-V M-extension divide/remainder semantics, including the divide-by-zero and overflow cases.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'(signed'(a));
    longint sb = longint'(signed'(b));
    logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Divider model: busy for lat cycles after the start pulse, result valid once busy drops.
  always @(posedge clk) begin
    if (!rst_n) begin
      dcnt <= 0;
      dres <= '0;
    end else if (div_en) begin
      dcnt <= lat;
      dres <= ref_div(div_op, div_rs1, div_rs2);
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign div_busy   = (dcnt != 0);
  assign div_result = dres;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_rs1[idx*XLEN +: XLEN] = a;
    req_rs2[idx*XLEN +: XLEN] = b;
    req_op[idx*3 +: 3]        = op;
  endtask

  // Request from one requester, wait (bounded) for its grant, then check the issue cycle.
  task automatic issue(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    set_req(idx, op, a, b);
    req_valid = 2'(1 << idx);
    settle();
    n = 0;
    while (req_ready == 0 && n < 10) begin
      tick(); settle(); n++;
    end
    check("grant", 64'(req_ready), 64'(1 << idx));
    tick();
    req_valid = '0;
    settle();
    check("div_en", 64'(div_en), 64'd1);
    check("div_rs1", 64'(div_rs1), 64'(a));
    check("div_rs2", 64'(div_rs2), 64'(b));
    check("div_op", 64'(div_op), 64'(op));
  endtask

  // From the issue cycle, wait (bounded) for the response, check it, and complete the handshake.
  task automatic collect(input int idx, input logic [31:0] exp, output int n);
    n = 0;
    while (resp_valid == 0 && n < 200) begin
      tick(); settle(); n++;
    end
    check("resp_valid", 64'(resp_valid), 64'(1 << idx));
    check("resp_result", 64'(resp_result), 64'(exp));
    tick(); settle();
    check("idle_after_resp", 64'({sched_busy, resp_valid}), 64'd0);
    exp_last = idx;
  endtask

  initial begin
    int n;
    int eg;
    logic bad;
    logic [31:0] ra, rb, r0, r1;
    logic [2:0]  rop;

    rst_n = 1'b0; req_valid = 2'b11; flush = '0; resp_ready = 2'b11;
    req_rs1 = '0; req_rs2 = '0; req_op = '0;
    tick(); tick(); settle();
    check("rst_ctl", 64'({req_ready, resp_valid, div_en, sched_busy}), 64'd0);
    check("rst_result", 64'(resp_result), 64'd0);
    rst_n = 1'b1;
    settle();
    check("rst_post_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    tick(); settle();

    // Single DIVU 100/7 with a 33-cycle divider: response lat+2 cycles after the issue cycle.
    lat = 33;
    issue(0, OP_DIVU, 32'd100, 32'd7);
    collect(0, 32'd14, n);
    check("latency", 64'(n), 64'(lat + 2));

    lat = 2;
    issue(1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    collect(1, 32'h8000_0000, n);

    for (int i = 0; i < 8; i++) begin
      eg  = int'($urandom_range(0, 1));
      rop = 3'(4 + $urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      lat = int'($urandom_range(1, 6));
      issue(eg, rop, ra, rb);
      collect(eg, ref_div(rop, ra, rb), n);
    end

    // Contention: both requesters held valid, grants must alternate.
    lat = 3;
    set_req(0, OP_DIV, 32'd1000, 32'hFFFF_FFFD);
    set_req(1, OP_REMU, 32'd1000, 32'd7);
    r0 = ref_div(OP_DIV, 32'd1000, 32'hFFFF_FFFD);
    r1 = ref_div(OP_REMU, 32'd1000, 32'd7);
    req_valid = 2'b11;
    eg = (exp_last + 1) % NREQ;
    for (int g = 0; g < 4; g++) begin
      settle();
      n = 0;
      while (req_ready == 0 && n < 10) begin
        tick(); settle(); n++;
      end
      check("rr_grant", 64'(req_ready), 64'(1 << eg));
      tick(); settle();
      if (g == 3) req_valid = '0;
      collect(eg, (eg == 0) ? r0 : r1, n);
      eg = (eg + 1) % NREQ;
    end
    req_valid = '0;
    settle();

    // Backpressure on requester 1 with requester 0 waiting.
    lat = 4;
    resp_ready = 2'b01;
    issue(1, OP_REM, 32'hFFFF_FFEF, 32'd5);
    set_req(0, OP_DIVU, 32'd9, 32'd3);
    req_valid = 2'b01;
    n = 0;
    while (resp_valid == 0 && n < 50) begin
      tick(); settle(); n++;
    end
    check("bp_valid", 64'(resp_valid), 64'(2'b10));
    check("bp_result", 64'(resp_result), 64'h0000_0000_FFFF_FFFE);
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(); settle();
      if (resp_valid !== 2'b10 || resp_result !== 32'hFFFF_FFFE || req_ready !== 2'b00) bad = 1'b1;
    end
    check("bp_hold", 64'(bad), 64'd0);
    resp_ready = 2'b11;
    tick(); settle();
    exp_last = 1;
    check("bp_next_grant", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = '0;
    settle();
    check("bp_div_en", 64'(div_en), 64'd1);
    collect(0, 32'd3, n);

    // Flush of the owner in WAIT: drain, no response, pending requester granted afterwards.
    lat = 10;
    issue(0, OP_DIVU, 32'd50, 32'd5);
    set_req(1, OP_DIV, 32'd77, 32'hFFFF_FFF9);
    req_valid = 2'b10;
    tick(); tick(); tick();
    flush = 2'b01;
    settle();
    check("fw_busy", 64'({sched_busy, resp_valid}), 64'(3'b100));
    tick();
    flush = '0;
    settle();
    bad = 1'b0;
    n = 0;
    while (div_busy && n < 30) begin
      if (resp_valid !== 2'b00 || req_ready !== 2'b00) bad = 1'b1;
      tick(); settle(); n++;
    end
    check("fw_drain_quiet", 64'({bad, req_ready, resp_valid}), 64'd0);
    tick(); settle();
    check("fw_next_grant", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = '0;
    settle();
    check("fw_div_en", 64'(div_en), 64'd1);
    collect(1, 32'hFFFF_FFF5, n);

    // Flush of the owner in ISSUE: start still pulses, no response, round-robin pointer unchanged.
    lat = 5;
    issue(0, OP_DIVU, 32'd8, 32'd2);
    flush = 2'b01;
    settle();
    check("fi_div_en", 64'(div_en), 64'd1);
    tick();
    flush = '0;
    settle();
    check("fi_drain", 64'(sched_busy), 64'd1);
    bad = 1'b0;
    n = 0;
    while (div_busy && n < 30) begin
      if (resp_valid !== 2'b00) bad = 1'b1;
      tick(); settle(); n++;
    end
    tick(); settle();
    check("fi_idle", 64'({bad, sched_busy, resp_valid}), 64'd0);
    set_req(0, OP_DIVU, 32'd81, 32'd9);
    set_req(1, OP_REMU, 32'd5, 32'd3);
    req_valid = 2'b11;
    settle();
    check("fi_rr_keep", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = '0;
    settle();
    check("fi_div_en2", 64'(div_en), 64'd1);
    collect(0, 32'd9, n);

    // Reset during WAIT: everything clears and index 0 wins first.
    lat = 20;
    issue(1, OP_DIV, 32'd100, 32'd3);
    tick(); tick(); tick();
    set_req(0, OP_DIVU, 32'd40, 32'd8);
    rst_n = 1'b0;
    req_valid = 2'b11;
    tick(); settle();
    check("rm_ctl", 64'({req_ready, resp_valid, div_en, sched_busy}), 64'd0);
    check("rm_result", 64'(resp_result), 64'd0);
    check("rm_rs1", 64'(div_rs1), 64'd0);
    rst_n = 1'b1;
    settle();
    check("rm_post_ready", 64'(req_ready), 64'd0);
    exp_last = NREQ - 1;
    tick(); settle();
    check("rm_first_grant", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = '0;
    settle();
    check("rm_div_en", 64'(div_en), 64'd1);
    collect(0, 32'd5, n);

    // Valid and flush together on requester 0 while 0 has priority: grant goes to 1.
    lat = 3;
    issue(1, OP_REMU, 32'd10, 32'd3);
    collect(1, 32'd1, n);
    set_req(0, OP_DIVU, 32'd12, 32'd4);
    set_req(1, OP_DIVU, 32'd21, 32'd7);
    req_valid = 2'b11;
    flush = 2'b01;
    settle();
    check("vf_grant", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = '0;
    flush = '0;
    settle();
    check("vf_div_rs1", 64'(div_rs1), 64'd21);
    collect(1, 32'd3, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
